// File: rtl/flag_stack_register_if.sv
// Bus between the controller and flag_stack_register: ALU flag inputs and
// stack strobes in one direction, live flags and stack status in the other.
interface flag_stack_register_if #(
  parameter int NFLAGS = 5,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              update;
  logic [NFLAGS-1:0] upd_mask;
  logic [NFLAGS-1:0] flags_in;
  logic              push;
  logic              pop;
  logic              err_clr;

  logic [NFLAGS-1:0] flags;
  logic              cy;
  logic              acy;
  logic              zero;
  logic              sgn;
  logic              parity;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;

  modport master (
    output update, upd_mask, flags_in, push, pop, err_clr,
    input  flags, cy, acy, zero, sgn, parity, count, full, empty, ovf, unf
  );

  modport slave (
    input  update, upd_mask, flags_in, push, pop, err_clr,
    output flags, cy, acy, zero, sgn, parity, count, full, empty, ovf, unf
  );
endinterface

// File: rtl/flag_stack_register.sv
// Live ALU flag register with masked update and a DEPTH-entry LIFO save/restore stack.
// Define FLAG_STACK_ERR_EN to build the sticky ovf/unf error registers.
module flag_stack_register #(
  parameter int NFLAGS = 5,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  flag_stack_register_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [NFLAGS-1:0] mem_q [0:(1<<AW)-1];

  logic              push_ok;
  logic              pop_ok;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;

  // A simultaneous push and pop cancels out: no stack traffic at all.
  assign push_ok = bus.push & ~bus.pop & ~full_q;
  assign pop_ok  = bus.pop & ~bus.push & ~empty_q;
  assign wr_idx  = AW'(count_q);
  assign rd_idx  = AW'(count_q - CW'(1));

  always_comb begin
    flags_d = flags_q;
    count_d = count_q;
    if (bus.update)
      flags_d = (bus.flags_in & bus.upd_mask) | (flags_q & ~bus.upd_mask);
    // Restore overrides any same-cycle ALU update.
    if (pop_ok) begin
      flags_d = mem_q[rd_idx];
      count_d = count_q - CW'(1);
    end else if (push_ok) begin
      count_d = count_q + CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // The stack holds the pre-update live value; no reset on the storage.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_idx] <= flags_q;
  end

  assign bus.flags  = flags_q;
  assign bus.cy     = flags_q[0];
  assign bus.acy    = flags_q[1];
  assign bus.zero   = flags_q[2];
  assign bus.sgn    = flags_q[3];
  assign bus.parity = flags_q[4];
  assign bus.count  = count_q;
  assign bus.full   = full_q;
  assign bus.empty  = empty_q;

`ifdef FLAG_STACK_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // A new error in the same cycle as err_clr still leaves the bit set.
  always_comb begin
    ovf_d = bus.err_clr ? 1'b0 : ovf_q;
    unf_d = bus.err_clr ? 1'b0 : unf_q;
    if (bus.push & ~bus.pop & full_q)
      ovf_d = 1'b1;
    if (bus.pop & ~bus.push & empty_q)
      unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = &{1'b0, bus.err_clr};
  assign bus.ovf = 1'b0;
  assign bus.unf = 1'b0;
`endif
endmodule

// File: doc/flag_stack_register.md
# flag_stack_register

Parametrised successor to the single-level ALU flag register: holds NFLAGS live status flags with per-bit masked update and adds a DEPTH-entry LIFO save/restore stack, so the controller can preserve flags across interrupts and subroutine calls. Sits between the ALU flag outputs and the controller. It replaces the fixed 5-flag latch wherever context save/restore is needed.

## Interface
- NFLAGS, 5: number of flags; must be ≥ 5. Bit 0 is cy, 1 acy, 2 zero, 3 sgn, 4 parity; higher bits are user flags.
- DEPTH, 4: stack entries; must be ≥ 1.
- CW, $clog2(DEPTH+1): width of the count output (derived).
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- update  input  1  latch the masked flags_in into the live register.
- upd_mask  input  NFLAGS  per-bit write enable applied when update=1.
- flags_in  input  NFLAGS  new flag values from the ALU.
- push  input  1  save the live flags to the top of the stack.
- pop  input  1  restore the live flags from the top of the stack.
- flags  output  NFLAGS  live flag register.
- cy, acy, zero, sgn, parity  output  1 each  named taps of flags[0..4].
- count  output  CW  number of occupied stack entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- ovf  output  1  sticky flag, set by a push while full (FLAG_STACK_ERR_EN only).
- unf  output  1  sticky flag, set by a pop while empty (FLAG_STACK_ERR_EN only).
- err_clr  input  1  clears ovf and unf (FLAG_STACK_ERR_EN only).

## Operation
- Live update: when update=1, bit i takes the value upd_mask[i] ? flags_in[i] : flags[i]. Masked-off bits hold their value.
- Push, legal when not full:
  - mem[count] <= flags, the pre-update value.
  - count increments.
  - A same-cycle update is still applied to the live register. The stacked copy is the old value.
- Pop, legal when not empty:
  - flags <= mem[count-1].
  - count decrements.
  - A same-cycle update is ignored, because restore wins.
- Push and pop in the same cycle:
  - No stack operation occurs and count is unchanged.
  - update applies normally.
  - Neither ovf nor unf is set.
- Push while full: the stack and count are unchanged, update still applies, and ovf is set.
- Pop while empty: flags and count are unchanged, update still applies, and unf is set.
- Stack memory has no reset. Entries at or above count are don't-care and are never visible on any output.
- The controller drives push and pop as single-cycle strobes. Holding a strobe high for N cycles performs N operations.

## Timing
- Reset values: flags=0 (all named taps 0), count=0, empty=1, full=0, ovf=0, unf=0.
- reset has priority over every other input in the same cycle. A reset asserted mid-operation discards all stacked context.
- All outputs are registered, with no combinational path from any input to any output.
  - full and empty decode count.
  - Each has 1-cycle latency: an input sampled at edge k is visible after edge k.
- Back-to-back push/pop is legal every cycle, with no bubbles.
- err_clr and a new error in the same cycle: the error wins, and the bit reads 1.

## Configuration
- Macro: FLAG_STACK_ERR_EN.
- Defined:
  - ovf and unf are sticky registers, set as described in Operation.
  - They are cleared only by reset or err_clr.
- Undefined:
  - ovf and unf are tied to 0 and no error registers are built.
  - err_clr is ignored.
  - Illegal push and pop are still silently ignored, with identical stack and flag behaviour.

## Test plan
- Reset, then update=1, upd_mask=5'b11111, flags_in=5'b10101 → after the edge, flags=5'b10101, parity=1, zero=1, cy=1.
- Masked update: with flags=5'b10101, update=1, upd_mask=5'b00011, flags_in=5'b01010 → flags=5'b10110.
- Nested save/restore (DEPTH=4): push 0x01, 0x02, 0x03 with updates in between, setting live to 0x04, then pop ×3 → flags 0x03, 0x02, 0x01. count goes 3→0 and empty=1 at the end.
- Overflow: fill 4 entries (full=1), push again → count stays 4 and ovf=1 (with the macro) or ovf=0 (without). The next 4 pops return the original 4 values.
- Underflow and collisions:
  - Pop at reset → flags unchanged and unf=1.
  - err_clr → unf=0.
  - push+pop with update in the same cycle → count unchanged and live flags updated.
- Reset mid-stack: with count=2, assert reset together with pop → flags=0, count=0, empty=1, no restore performed.
